adder_subtractor: RTL and testbench

ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

---
 rtl/adder_subtractor.sv | 45 ++++
 tb/tb_adder_subtractor.sv | 81 ++++++++
 2 files changed

// File: rtl/adder_subtractor.sv
// adder_subtractor: registered ripple-carry add/subtract with carry, overflow, zero and sign flags
module adder_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  input  logic             EN,
  output logic [WIDTH-1:0] ANSWER,
  output logic             VALID,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             ZERO,
  output logic             NEG
);
  logic [WIDTH-1:0] bx, sum;
  logic [WIDTH:0]   c;
  assign bx   = B ^ {WIDTH{S}};
  assign c[0] = S;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = A[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ANSWER   <= '0;
      VALID    <= 1'b0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
      ZERO     <= 1'b1;
      NEG      <= 1'b0;
    end else begin
      VALID <= EN;
      if (EN) begin
        ANSWER   <= sum;
        CARRY    <= c[WIDTH];
        OVERFLOW <= c[WIDTH] ^ c[WIDTH-1];
        ZERO     <= ~|sum;
        NEG      <= sum[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_adder_subtractor.sv
// tb_adder_subtractor: directed-vector bench with immediate assertions on every output
module tb_adder_subtractor;
  logic       clk = 1'b0;
  logic       reset, s, en;
  logic [5:0] a, b, answer;
  logic       valid, carry, overflow, zero, neg;
  int         n_assert = 0;
  int         n_fail = 0;

  adder_subtractor #(.WIDTH(6)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .S(s), .EN(en),
    .ANSWER(answer), .VALID(valid), .CARRY(carry), .OVERFLOW(overflow),
    .ZERO(zero), .NEG(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input int av, input int bv, input logic sv);
    reset = r;
    en    = e;
    a     = 6'(av);
    b     = 6'(bv);
    s     = sv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_all(input string tag, input int ans, input int c, input int o,
                            input int z, input int n, input int v);
    check({tag, ".answer"},   int'(answer),   ans);
    check({tag, ".carry"},    int'(carry),    c);
    check({tag, ".overflow"}, int'(overflow), o);
    check({tag, ".zero"},     int'(zero),     z);
    check({tag, ".neg"},      int'(neg),      n);
    check({tag, ".valid"},    int'(valid),    v);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_all("reset", 0, 0, 0, 1, 0, 0);
    step(0, 1, 3, 11, 0);
    expect_all("add_3_11", 14, 0, 0, 0, 0, 1);
    step(0, 1, 11, 3, 1);
    expect_all("sub_11_3", 8, 1, 0, 0, 0, 1);
    step(0, 1, 3, 11, 1);
    expect_all("sub_3_11", 56, 0, 0, 0, 1, 1);
    step(0, 1, 63, 1, 0);
    expect_all("add_wrap", 0, 1, 0, 1, 0, 1);
    step(0, 1, 31, 1, 0);
    expect_all("add_ovf", 32, 0, 1, 0, 1, 1);
    step(0, 1, 32, 1, 1);
    expect_all("sub_ovf", 31, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    expect_all("sub_0_0", 0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 1);
    expect_all("sub_0_1", 63, 0, 0, 0, 1, 1);
    step(0, 1, 3, 11, 0);
    expect_all("reload", 14, 0, 0, 0, 0, 1);
    step(0, 0, 63, 1, 0);
    expect_all("hold1", 14, 0, 0, 0, 0, 0);
    step(0, 0, 31, 1, 1);
    expect_all("hold2", 14, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    expect_all("hold3", 14, 0, 0, 0, 0, 0);
    step(1, 1, 5, 5, 0);
    expect_all("rst_prio", 0, 0, 0, 1, 0, 0);
    step(0, 1, 5, 5, 0);
    expect_all("post_rst", 10, 0, 0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
